img_sram_loader: RTL



---
 rtl/img_sram_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/img_sram_loader.sv
// ============================================================================
// Module   : img_sram_loader
// Purpose  : Streams a raster-order image into four banked img SRAMs using the
//            3x3-tile word layout (one address per bank = 6x6 neighbourhood).
//            Optional macro IMG_LOADER_CENTER_EN stores channels as signed v-128.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_sram_loader #(
    parameter int IMG_W        = 24,
    parameter int IMG_H        = 24,
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 9,
    parameter int BW_PER_ACT   = 10,
    parameter int BW_PER_PIX   = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [CH_NUM*BW_PER_PIX-1:0]             in_data,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     sram_wen_img_0,
    output logic                                     sram_wen_img_1,
    output logic                                     sram_wen_img_2,
    output logic                                     sram_wen_img_3,
    output logic [CH_NUM*ACT_PER_ADDR-1:0]           sram_wordmask_img,
    output logic [13:0]                              sram_waddr_img,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata_img
);

    localparam int c_XW       = $clog2(IMG_W);
    localparam int c_YW       = $clog2(IMG_H);
    localparam int c_MW       = CH_NUM * ACT_PER_ADDR;
    localparam int c_DW       = c_MW * BW_PER_ACT;
    localparam int c_AW       = 14;
    localparam int c_MIW      = $clog2(c_MW);
    localparam int c_DIW      = $clog2(c_DW);
    localparam int c_TILES_X2 = IMG_W / 6;
    localparam logic [c_XW-1:0] c_LAST_X = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_LAST_Y = c_YW'(IMG_H - 1);
`ifdef IMG_LOADER_CENTER_EN
    localparam logic [BW_PER_ACT-1:0] c_CENTER = BW_PER_ACT'(1 << (BW_PER_PIX - 1));
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_XW-1:0] r_px;
    logic [c_XW-1:0] r_tc;
    logic [1:0]      r_xm3;
    logic [c_YW-1:0] r_py;
    logic [c_YW-1:0] r_tr;
    logic [1:0]      r_ym3;

    logic [3:0]      r_wen;
    logic [c_MW-1:0] r_mask;
    logic [c_AW-1:0] r_waddr;
    logic [c_DW-1:0] r_wdata;

    logic            w_acc;
    logic            w_last;
    logic [3:0]      w_slot;
    logic [1:0]      w_bank;
    logic [c_AW-1:0] w_addr;
    logic [c_MW-1:0] w_mask_nxt;
    logic [c_DW-1:0] w_data_nxt;
    logic [c_MIW-1:0] w_midx;
    logic [c_DIW-1:0] w_didx;

    function automatic logic [BW_PER_ACT-1:0] f_conv(input logic [BW_PER_PIX-1:0] v);
`ifdef IMG_LOADER_CENTER_EN
        return {{(BW_PER_ACT-BW_PER_PIX){1'b0}}, v} - c_CENTER;
`else
        return {{(BW_PER_ACT-BW_PER_PIX){1'b0}}, v};
`endif
    endfunction

    assign w_acc  = in_valid && (r_state == S_LOAD);
    assign w_last = w_acc && (r_px == c_LAST_X) && (r_py == c_LAST_Y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Position counters; mod-3 sub-counters carry into the tile column/row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_px  <= '0;
            r_tc  <= '0;
            r_xm3 <= '0;
            r_py  <= '0;
            r_tr  <= '0;
            r_ym3 <= '0;
        end else if (w_acc) begin
            if (r_px == c_LAST_X) begin
                r_px  <= '0;
                r_tc  <= '0;
                r_xm3 <= '0;
                if (r_py == c_LAST_Y) begin
                    r_py  <= '0;
                    r_tr  <= '0;
                    r_ym3 <= '0;
                end else begin
                    r_py <= r_py + c_YW'(1);
                    if (r_ym3 == 2'd2) begin
                        r_ym3 <= '0;
                        r_tr  <= r_tr + c_YW'(1);
                    end else begin
                        r_ym3 <= r_ym3 + 2'd1;
                    end
                end
            end else begin
                r_px <= r_px + c_XW'(1);
                if (r_xm3 == 2'd2) begin
                    r_xm3 <= '0;
                    r_tc  <= r_tc + c_XW'(1);
                end else begin
                    r_xm3 <= r_xm3 + 2'd1;
                end
            end
        end
    end

    assign w_slot = {1'b0, r_ym3, 1'b0} + {2'b00, r_ym3} + {2'b00, r_xm3};
    assign w_bank = {r_tr[0], r_tc[0]};
    assign w_addr = c_AW'(int'(r_tr >> 1) * c_TILES_X2 + int'(r_tc >> 1));

    always_comb begin
        w_mask_nxt = '1;
        w_data_nxt = '0;
        w_midx     = '0;
        w_didx     = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_midx             = c_MIW'(c * ACT_PER_ADDR + int'(w_slot));
            w_didx             = c_DIW'((c * ACT_PER_ADDR + int'(w_slot)) * BW_PER_ACT);
            w_mask_nxt[w_midx] = 1'b0;
            w_data_nxt[w_didx +: BW_PER_ACT] = f_conv(in_data[c*BW_PER_PIX +: BW_PER_PIX]);
        end
    end

    // Address and data hold between writes; only enables and mask idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= '1;
            r_mask  <= '1;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_acc) begin
            r_wen   <= ~(4'b0001 << w_bank);
            r_mask  <= w_mask_nxt;
            r_waddr <= w_addr;
            r_wdata <= w_data_nxt;
        end else begin
            r_wen  <= '1;
            r_mask <= '1;
        end
    end

    assign sram_wen_img_0    = r_wen[0];
    assign sram_wen_img_1    = r_wen[1];
    assign sram_wen_img_2    = r_wen[2];
    assign sram_wen_img_3    = r_wen[3];
    assign sram_wordmask_img = r_mask;
    assign sram_waddr_img    = r_waddr;
    assign sram_wdata_img    = r_wdata;

endmodule

`default_nettype wire
